// File: rtl/pool_pkg.sv
// Shared definitions for the streaming 2D pooling engine: defaults, mode
// encodings, state type and accumulator width derivation.
package pool_pkg;

    localparam int DWIDTH_DEFAULT      = 8;
    localparam int DESIGN_SIZE_DEFAULT = 16;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } pool_state_t;

    // Six extra bits hold the sum of an 8x8 window of elements.
    function automatic int acc_width(input int dwidth);
        return dwidth + 6;
    endfunction

endpackage

// File: rtl/pool_hreduce.sv
// Combinational masked horizontal reduction: per group of 1 << win_log2 lanes,
// the running max or the sign-extended sum of the valid lanes in one row.
module pool_hreduce
    import pool_pkg::*;
#(
    parameter int DWIDTH      = DWIDTH_DEFAULT,
    parameter int DESIGN_SIZE = DESIGN_SIZE_DEFAULT,
    parameter int ACC_WIDTH   = acc_width(DWIDTH)
) (
    input  logic [DESIGN_SIZE*DWIDTH-1:0]             row_data,
    input  logic [DESIGN_SIZE-1:0]                    row_mask,
    input  logic [1:0]                                win_log2,
    input  logic                                      mode,
    output logic [DESIGN_SIZE-1:0][ACC_WIDTH-1:0]     grp_val,
    output logic [DESIGN_SIZE-1:0]                    grp_any
);

    localparam int GW = $clog2(DESIGN_SIZE);

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        grp_val = '0;
        grp_any = '0;
        for (int i = 0; i < DESIGN_SIZE; i++) begin
            logic [GW-1:0]               g;
            logic signed [ACC_WIDTH-1:0] elem;
            g    = GW'(i >> win_log2);
            elem = ACC_WIDTH'($signed(row_data[i*DWIDTH +: DWIDTH]));
            if (row_mask[i]) begin
                if (mode == POOL_AVG) begin
                    grp_val[g] = grp_val[g] + elem;
                end else if (!grp_any[g] || elem > $signed(grp_val[g])) begin
                    grp_val[g] = elem;
                end
                grp_any[g] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pool_2d_engine.sv
// Streaming 2D max/average pooling over square windows of 1/2/4/8, with
// per-lane masking, row-counted tiles and a registered bypass path.
module pool_2d_engine
    import pool_pkg::*;
#(
    parameter int DWIDTH        = DWIDTH_DEFAULT,
    parameter int DESIGN_SIZE   = DESIGN_SIZE_DEFAULT,
    parameter int ACC_WIDTH     = acc_width(DWIDTH),
    parameter int ROW_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable_pool,
    input  logic                          pool_mode,
    input  logic [1:0]                    pool_window_log2,
    input  logic [ROW_CNT_WIDTH-1:0]      rows_total,
    input  logic                          in_data_available,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
    input  logic [DESIGN_SIZE-1:0]        validity_mask,
    output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
    output logic                          out_data_available,
    output logic                          done_pool
);

    pool_state_t                          state_q, state_d;
    logic                                 mode_q, mode_d;
    logic [1:0]                           log2_q, log2_d;
    logic [ROW_CNT_WIDTH-1:0]             rows_total_q, rows_total_d;
    logic [ROW_CNT_WIDTH-1:0]             row_cnt_q, row_cnt_d;
    logic [2:0]                           win_cnt_q, win_cnt_d;
    logic [DESIGN_SIZE-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
    logic [DESIGN_SIZE-1:0]               any_q, any_d;
    logic [DESIGN_SIZE*DWIDTH-1:0]        out_data_q, out_data_d;
    logic                                 out_valid_q, out_valid_d;
    logic                                 done_q, done_d;

    // The first row of a tile uses the live configuration; later rows use the latched copy.
    logic                                 mode_eff;
    logic [1:0]                           log2_eff;
    logic [ROW_CNT_WIDTH-1:0]             rows_eff;
    logic [ROW_CNT_WIDTH-1:0]             row_next;
    logic                                 win_last;
    logic                                 tile_last;

    logic [DESIGN_SIZE-1:0][ACC_WIDTH-1:0] h_val;
    logic [DESIGN_SIZE-1:0]               h_any;
    logic [DESIGN_SIZE-1:0][ACC_WIDTH-1:0] fold_val;
    logic [DESIGN_SIZE-1:0]               fold_any;
    logic [DESIGN_SIZE*DWIDTH-1:0]        beat_data;

    assign mode_eff  = (state_q == ST_IDLE) ? pool_mode        : mode_q;
    assign log2_eff  = (state_q == ST_IDLE) ? pool_window_log2 : log2_q;
    assign rows_eff  = (state_q == ST_IDLE) ? rows_total       : rows_total_q;
    assign row_next  = row_cnt_q + 1'b1;
    assign win_last  = (win_cnt_q == ((3'd1 << log2_eff) - 3'd1));
    assign tile_last = (row_next == rows_eff);

    pool_hreduce #(
        .DWIDTH      (DWIDTH),
        .DESIGN_SIZE (DESIGN_SIZE),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_hreduce (
        .row_data (inp_data),
        .row_mask (validity_mask),
        .win_log2 (log2_eff),
        .mode     (mode_eff),
        .grp_val  (h_val),
        .grp_any  (h_any)
    );

    // Fold this row into the accumulators and form the beat that would leave if the window closed now.
    always_comb begin
        fold_val  = '0;
        fold_any  = '0;
        beat_data = '0;
        for (int g = 0; g < DESIGN_SIZE; g++) begin
            logic [ACC_WIDTH-1:0] shifted;
            if (mode_eff == POOL_AVG) begin
                fold_val[g] = acc_q[g] + h_val[g];
            end else if (h_any[g] && (!any_q[g] || $signed(h_val[g]) > $signed(acc_q[g]))) begin
                fold_val[g] = h_val[g];
            end else begin
                fold_val[g] = acc_q[g];
            end
            fold_any[g] = any_q[g] | h_any[g];
            shifted     = $signed(fold_val[g]) >>> {log2_eff, 1'b0};
            if (g < (DESIGN_SIZE >> log2_eff)) begin
                if (mode_eff == POOL_AVG) begin
                    beat_data[g*DWIDTH +: DWIDTH] = shifted[DWIDTH-1:0];
                end else if (fold_any[g]) begin
                    beat_data[g*DWIDTH +: DWIDTH] = fold_val[g][DWIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        log2_d       = log2_q;
        rows_total_d = rows_total_q;
        row_cnt_d    = row_cnt_q;
        win_cnt_d    = win_cnt_q;
        acc_d        = acc_q;
        any_d        = any_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        done_d       = 1'b0;

        if (!enable_pool) begin
            // Bypass, and abort of any tile in flight.
            state_d     = ST_IDLE;
            row_cnt_d   = '0;
            win_cnt_d   = '0;
            acc_d       = '0;
            any_d       = '0;
            out_data_d  = inp_data;
            out_valid_d = in_data_available;
        end else if (in_data_available) begin
            if (state_q == ST_IDLE) begin
                mode_d       = pool_mode;
                log2_d       = pool_window_log2;
                rows_total_d = rows_total;
            end
            if (state_q == ST_IDLE && rows_total == '0) begin
                done_d = 1'b1;
            end else if (win_last || tile_last) begin
                out_data_d  = beat_data;
                out_valid_d = 1'b1;
                acc_d       = '0;
                any_d       = '0;
                win_cnt_d   = '0;
                if (tile_last) begin
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                    row_cnt_d = '0;
                end else begin
                    state_d   = ST_ACCUM;
                    row_cnt_d = row_next;
                end
            end else begin
                acc_d     = fold_val;
                any_d     = fold_any;
                win_cnt_d = win_cnt_q + 1'b1;
                row_cnt_d = row_next;
                state_d   = ST_ACCUM;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: the accumulators are flops, not a RAM, so they are cleared by reset like the rest.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= POOL_MAX;
            log2_q       <= '0;
            rows_total_q <= '0;
            row_cnt_q    <= '0;
            win_cnt_q    <= '0;
            acc_q        <= '0;
            any_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            log2_q       <= log2_d;
            rows_total_q <= rows_total_d;
            row_cnt_q    <= row_cnt_d;
            win_cnt_q    <= win_cnt_d;
            acc_q        <= acc_d;
            any_q        <= any_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
        end
    end

    assign out_data           = out_data_q;
    assign out_data_available = out_valid_q;
    assign done_pool          = done_q;

endmodule

// File: tb/tb_pool_2d_engine.sv
// Directed bench for pool_2d_engine: a table of single-row vectors followed
// by hand-written multi-row windows, masking, partial tile, abort and reset.
module tb_pool_2d_engine;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable_pool;
    logic         pool_mode;
    logic [1:0]   pool_window_log2;
    logic [15:0]  rows_total;
    logic         in_data_available;
    logic [127:0] inp_data;
    logic [15:0]  validity_mask;
    logic [127:0] out_data;
    logic         out_data_available;
    logic         done_pool;

    int n_checks = 0;
    int n_errors = 0;

    pool_2d_engine dut (
        .clk                (clk),
        .reset              (reset),
        .enable_pool        (enable_pool),
        .pool_mode          (pool_mode),
        .pool_window_log2   (pool_window_log2),
        .rows_total         (rows_total),
        .in_data_available  (in_data_available),
        .inp_data           (inp_data),
        .validity_mask      (validity_mask),
        .out_data           (out_data),
        .out_data_available (out_data_available),
        .done_pool          (done_pool)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic         mode;
        logic [1:0]   lg;
        logic [15:0]  rows;
        logic         av;
        logic [15:0]  mask;
        logic [127:0] din;
        logic [127:0] exp_data;
        logic         exp_valid;
        logic         exp_done;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; after the call the outputs reflect this row.
    task automatic row(input logic en, input logic av, input logic [127:0] d, input logic [15:0] m);
        enable_pool       = en;
        in_data_available = av;
        inp_data          = d;
        validity_mask     = m;
        @(negedge clk);
    endtask

    task automatic cfg(input logic mode, input logic [1:0] lg, input logic [15:0] rows);
        pool_mode        = mode;
        pool_window_log2 = lg;
        rows_total       = rows;
    endtask

    task automatic check_out(input string name, input logic [127:0] d, input logic v, input logic dn);
        check({name, ".data"},  out_data, d);
        check({name, ".valid"}, 128'(out_data_available), 128'(v));
        check({name, ".done"},  128'(done_pool), 128'(dn));
    endtask

    initial begin
        logic [127:0] d0, d1, dc;

        vecs[0] = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b1, 16'hFFFF,
                    128'h10_0f_0e_0d_0c_0b_0a_09_08_07_06_05_04_03_02_01,
                    128'h10_0f_0e_0d_0c_0b_0a_09_08_07_06_05_04_03_02_01, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 16'h0000,
                    128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D,
                    128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 2'd0, 16'd1, 1'b1, 16'hFFFF,
                    128'h10_0f_0e_0d_0c_0b_0a_09_08_07_06_05_04_03_02_01,
                    128'h10_0f_0e_0d_0c_0b_0a_09_08_07_06_05_04_03_02_01, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 2'd0, 16'd1, 1'b1, 16'h00FF,
                    {16{8'h85}}, {64'h0, {8{8'h85}}}, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 2'd0, 16'd1, 1'b1, 16'hF0F0,
                    {16{8'hFE}}, 128'hFEFEFEFE_00000000_FEFEFEFE_00000000, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 2'd3, 16'd1, 1'b1, 16'hFFFF,
                    {16{8'h08}}, 128'h0101, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 2'd3, 16'd1, 1'b1, 16'hFFFF,
                    128'h07_06_05_04_03_02_01_00_ff_fe_fd_fc_fb_fa_f9_f8,
                    128'h07ff, 1'b1, 1'b1};

        reset = 1'b1;
        cfg(1'b0, 2'd0, 16'd0);
        enable_pool = 1'b0; in_data_available = 1'b0; inp_data = '0; validity_mask = '1;
        repeat (2) @(negedge clk);
        check_out("reset", 128'h0, 1'b0, 1'b0);
        reset = 1'b0;

        for (int k = 0; k < 7; k++) begin
            cfg(vecs[k].mode, vecs[k].lg, vecs[k].rows);
            row(vecs[k].en, vecs[k].av, vecs[k].din, vecs[k].mask);
            check_out($sformatf("vec%0d", k), vecs[k].exp_data, vecs[k].exp_valid, vecs[k].exp_done);
            row(1'b0, 1'b0, '0, '1);
        end

        // w=2 max over two rows: lane i = i, then 15-i.
        for (int i = 0; i < 16; i++) begin
            d0[i*8 +: 8] = 8'(i);
            d1[i*8 +: 8] = 8'(15 - i);
            dc[i*8 +: 8] = 8'((i / 4) * 4);
        end
        cfg(1'b0, 2'd1, 16'd2);
        row(1'b1, 1'b1, d0, '1);
        check_out("max2_r0", 128'h0, 1'b0, 1'b0);
        row(1'b1, 1'b1, d1, '1);
        check_out("max2_r1", 128'h0f0d0b09090b0d0f, 1'b1, 1'b1);
        row(1'b1, 1'b0, '0, '1);
        check("max2_after.valid", 128'(out_data_available), 128'h0);
        check("max2_after.done",  128'(done_pool), 128'h0);

        // w=4 average, four identical rows.
        cfg(1'b1, 2'd2, 16'd4);
        for (int r = 0; r < 3; r++) begin
            row(1'b1, 1'b1, dc, '1);
            check("avg4_mid.valid", 128'(out_data_available), 128'h0);
        end
        row(1'b1, 1'b1, dc, '1);
        check_out("avg4", 128'h0c080400, 1'b1, 1'b1);

        // w=2 average floor rounding of a single -1.
        cfg(1'b1, 2'd1, 16'd2);
        row(1'b1, 1'b1, 128'hff, '1);
        row(1'b1, 1'b1, 128'h0, '1);
        check_out("avg2_floor", 128'hff, 1'b1, 1'b1);

        // Masking in max mode.
        cfg(1'b0, 2'd1, 16'd1);
        row(1'b1, 1'b1, 128'h0564, 16'hFFFE);
        check_out("mask_one", 128'h05, 1'b1, 1'b1);
        row(1'b1, 1'b1, 128'h0564, 16'hFFFC);
        check_out("mask_all", 128'h00, 1'b1, 1'b1);

        // Partial tile, with a gap and a config change that must be ignored.
        cfg(1'b1, 2'd2, 16'd6);
        for (int r = 0; r < 3; r++) row(1'b1, 1'b1, {16{8'h10}}, '1);
        row(1'b1, 1'b1, {16{8'h10}}, '1);
        check_out("part_beat1", 128'h10101010, 1'b1, 1'b0);
        cfg(1'b0, 2'd0, 16'd1);
        row(1'b1, 1'b1, {16{8'h10}}, '1);
        check("part_r5.valid", 128'(out_data_available), 128'h0);
        row(1'b1, 1'b0, {16{8'h7f}}, '1);
        check("part_gap.valid", 128'(out_data_available), 128'h0);
        row(1'b1, 1'b1, {16{8'h10}}, '1);
        check_out("part_beat2", 128'h08080808, 1'b1, 1'b1);

        // Abort after two of four rows, then a fresh w=1 tile.
        cfg(1'b1, 2'd2, 16'd4);
        row(1'b1, 1'b1, {16{8'h10}}, '1);
        row(1'b1, 1'b1, {16{8'h10}}, '1);
        row(1'b0, 1'b0, '0, '1);
        check("abort.valid", 128'(out_data_available), 128'h0);
        check("abort.done",  128'(done_pool), 128'h0);
        cfg(1'b0, 2'd0, 16'd1);
        row(1'b1, 1'b1, vecs[0].din, '1);
        check_out("abort_fresh", vecs[0].din, 1'b1, 1'b1);

        // Reset mid-tile.
        cfg(1'b0, 2'd1, 16'd2);
        row(1'b1, 1'b1, {16{8'h70}}, '1);
        reset = 1'b1;
        row(1'b1, 1'b1, {16{8'h70}}, '1);
        check_out("reset_mid", 128'h0, 1'b0, 1'b0);
        reset = 1'b0;
        cfg(1'b0, 2'd0, 16'd1);
        row(1'b1, 1'b1, vecs[0].din, '1);
        check_out("reset_fresh", vecs[0].din, 1'b1, 1'b1);

        // rows_total = 0: no beat, done on the following cycle.
        cfg(1'b0, 2'd1, 16'd0);
        row(1'b1, 1'b1, {16{8'h22}}, '1);
        check("zero.valid", 128'(out_data_available), 128'h0);
        check("zero.done",  128'(done_pool), 128'h1);
        row(1'b1, 1'b0, '0, '1);
        check("zero_after.done", 128'(done_pool), 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
